// File: rtl/bellek_hakemi_if.sv
// Bus bundle between the core, the memory arbiter and the shared single-port memory.
// slave is the arbiter's view; master is the core/memory side that drives requests and read data.
interface bellek_hakemi_if #(
   parameter int ADRES_BIT = 32,
   parameter int VERI_BIT  = 32
);
   logic                 b_istek;
   logic [ADRES_BIT-1:0] b_adres;
   logic                 b_hazir;
   logic                 b_gecerli;
   logic [VERI_BIT-1:0]  b_veri;

   logic                 v_istek;
   logic [ADRES_BIT-1:0] v_adres;
   logic                 v_yaz;
   logic [VERI_BIT-1:0]  v_yaz_veri;
   logic                 v_hazir;
   logic                 v_gecerli;
   logic [VERI_BIT-1:0]  v_veri;
   logic                 v_hata;

   logic [ADRES_BIT-1:0] bellek_adres;
   logic                 bellek_yaz;
   logic [VERI_BIT-1:0]  bellek_yaz_veri;
   logic [VERI_BIT-1:0]  bellek_oku_veri;

   modport slave (
      input  b_istek, b_adres,
      input  v_istek, v_adres, v_yaz, v_yaz_veri,
      input  bellek_oku_veri,
      output b_hazir, b_gecerli, b_veri,
      output v_hazir, v_gecerli, v_veri, v_hata,
      output bellek_adres, bellek_yaz, bellek_yaz_veri
   );

   modport master (
      output b_istek, b_adres,
      output v_istek, v_adres, v_yaz, v_yaz_veri,
      output bellek_oku_veri,
      input  b_hazir, b_gecerli, b_veri,
      input  v_hazir, v_gecerli, v_veri, v_hata,
      input  bellek_adres, bellek_yaz, bellek_yaz_veri
   );
endinterface

// File: rtl/bellek_hakemi.sv
// Round-robin arbiter giving the fetch (b) and load/store (v) sides turns on one
// single-port memory, one outstanding access at a time.
//
// state  | meaning
// BOSTA  | idle; grant a pending request, pulse x_gecerli of the access just finished
// ERISIM | memory access in flight; sayac counts down the read latency
module bellek_hakemi #(
   parameter int ADRES_BIT = 32,
   parameter int VERI_BIT  = 32,
   parameter int GECIKME   = 0
) (
   input logic           clk,
   input logic           rst,
   bellek_hakemi_if.slave bus
);

   localparam int SAYAC_BIT = (GECIKME < 1) ? 1 : $clog2(GECIKME + 1);

   typedef enum logic {BOSTA, ERISIM} durum_t;
   typedef enum logic {KAZANAN_B, KAZANAN_V} kazanan_t;

   durum_t               durum;
   durum_t               durum_sonraki;
   kazanan_t             son_kazanan;
   logic [SAYAC_BIT-1:0] sayac;
   logic                 aktif_v;
   logic                 aktif_yaz;
   logic                 kabul_b;
   logic                 kabul_v;
   logic                 hizali;

   logic                 b_gecerli_r;
   logic [VERI_BIT-1:0]  b_veri_r;
   logic                 v_gecerli_r;
   logic [VERI_BIT-1:0]  v_veri_r;
   logic                 v_hata_r;
   logic [ADRES_BIT-1:0] bellek_adres_r;
   logic                 bellek_yaz_r;
   logic [VERI_BIT-1:0]  bellek_yaz_veri_r;

   assign hizali = (bus.v_adres[1:0] == 2'b00);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) durum <= BOSTA;
      else     durum <= durum_sonraki;
   end

   // On a tie the side that did not win last time is granted.
   always_comb begin
      durum_sonraki = durum;
      kabul_b       = 1'b0;
      kabul_v       = 1'b0;
      case (durum)
         BOSTA: begin
            if (bus.b_istek && (!bus.v_istek || son_kazanan == KAZANAN_V))
               kabul_b = 1'b1;
            else if (bus.v_istek)
               kabul_v = 1'b1;
            if (kabul_b || (kabul_v && hizali))
               durum_sonraki = ERISIM;
         end
         ERISIM: begin
            if (sayac == '0)
               durum_sonraki = BOSTA;
         end
         default: durum_sonraki = BOSTA;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         son_kazanan       <= KAZANAN_V;
         sayac             <= '0;
         aktif_v           <= 1'b0;
         aktif_yaz         <= 1'b0;
         b_gecerli_r       <= 1'b0;
         b_veri_r          <= '0;
         v_gecerli_r       <= 1'b0;
         v_veri_r          <= '0;
         v_hata_r          <= 1'b0;
         bellek_adres_r    <= '0;
         bellek_yaz_r      <= 1'b0;
         bellek_yaz_veri_r <= '0;
      end else begin
         b_gecerli_r <= 1'b0;
         v_gecerli_r <= 1'b0;
         v_hata_r    <= 1'b0;
         case (durum)
            BOSTA: begin
               if (kabul_b) begin
                  son_kazanan    <= KAZANAN_B;
                  aktif_v        <= 1'b0;
                  aktif_yaz      <= 1'b0;
                  bellek_adres_r <= bus.b_adres;
                  bellek_yaz_r   <= 1'b0;
                  sayac          <= SAYAC_BIT'(GECIKME);
               end else if (kabul_v) begin
                  son_kazanan <= KAZANAN_V;
                  if (hizali) begin
                     aktif_v           <= 1'b1;
                     aktif_yaz         <= bus.v_yaz;
                     bellek_adres_r    <= bus.v_adres;
                     bellek_yaz_r      <= bus.v_yaz;
                     bellek_yaz_veri_r <= bus.v_yaz_veri;
                     sayac             <= SAYAC_BIT'(GECIKME);
                  end else begin
                     // Misaligned access never reaches the memory; it completes with an error.
                     v_gecerli_r <= 1'b1;
                     v_hata_r    <= 1'b1;
                  end
               end
            end
            ERISIM: begin
               bellek_yaz_r <= 1'b0;
               if (sayac != '0) begin
                  sayac <= sayac - SAYAC_BIT'(1);
               end else if (aktif_v) begin
                  v_gecerli_r <= 1'b1;
                  if (!aktif_yaz) v_veri_r <= bus.bellek_oku_veri;
               end else begin
                  b_gecerli_r <= 1'b1;
                  b_veri_r    <= bus.bellek_oku_veri;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.b_hazir         = kabul_b;
   assign bus.v_hazir         = kabul_v;
   assign bus.b_gecerli       = b_gecerli_r;
   assign bus.b_veri          = b_veri_r;
   assign bus.v_gecerli       = v_gecerli_r;
   assign bus.v_veri          = v_veri_r;
   assign bus.v_hata          = v_hata_r;
   assign bus.bellek_adres    = bellek_adres_r;
   assign bus.bellek_yaz      = bellek_yaz_r;
   assign bus.bellek_yaz_veri = bellek_yaz_veri_r;

endmodule
